// File: rtl/fsm_monitor.sv
// fsm_monitor: board-level companion for the lab FSMs.
//
// Produces the one-cycle step pulse that clocks the FSM under test,
// either free-running at TICK_HZ or one pulse per debounced push of
// step_btn. It also counts transitions and multiplexes an NUM_DIG-digit
// seven-segment display showing the FSM's output (d0), its state (d2)
// and the transition count (d4 upwards).
//
// Ports:
//   clk        board clock
//   reset      asynchronous, active-low reset
//   run        1 = free-run, 0 = halt / single-step (synchronised inside)
//   step_btn   raw push-button, active-high
//   dut_state  current state of the FSM under test
//   dut_out    output of the FSM under test
//   fsm_tick   one-cycle step pulse for the FSM under test
//   AN         digit enables, active-low, one-hot
//   CA         segments {g,f,e,d,c,b,a}, active-low
//
// Build option: define FSM_MONITOR_STEP_EN to include the single-step
// path (synchroniser, debouncer, edge detect). Without it, step_btn is
// ignored and run=0 simply halts the FSM.

module fsm_monitor #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1,
    parameter int SCAN_HZ = 1000,
    parameter int DEB_CYC = 1_000_000,
    parameter int STATE_W = 3,
    parameter int OUT_W   = 1,
    parameter int NUM_DIG = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               step_btn,
    input  logic [STATE_W-1:0] dut_state,
    input  logic [OUT_W-1:0]   dut_out,
    output logic               fsm_tick,
    output logic [NUM_DIG-1:0] AN,
    output logic [6:0]         CA
);

    localparam int DIV      = CLK_HZ / TICK_HZ;
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int DIV_W    = $clog2(DIV);
    localparam int SCAN_W   = $clog2(SCAN_DIV);
    localparam int IDX_W    = $clog2(NUM_DIG);
    localparam int CNT_W    = 4 * (NUM_DIG - 4);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIG - 1);

    function automatic logic [6:0] seg_font(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // ---------------- run synchroniser and free-run divider ----------------
    logic             run_meta;
    logic             run_s;
    logic [DIV_W-1:0] div_cnt;
    logic             div_hit;
    logic             step_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_meta <= 1'b0;
            run_s    <= 1'b0;
        end else begin
            run_meta <= run;
            run_s    <= run_meta;
        end
    end

    // Held at 0 while halted so that resuming always restarts a full period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (!run_s || div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Not gated by run_s: a halt arriving in the terminal cycle keeps its tick.
    assign div_hit = (div_cnt == DIV_LAST);

    // ---------------- single-step path ----------------
`ifdef FSM_MONITOR_STEP_EN
    localparam int DEB_W = $clog2(DEB_CYC + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

    logic             btn_meta;
    logic             btn_s;
    logic             btn_deb;
    logic             btn_deb_d;
    logic [DEB_W-1:0] deb_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta  <= 1'b0;
            btn_s     <= 1'b0;
            btn_deb   <= 1'b0;
            btn_deb_d <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            btn_meta  <= step_btn;
            btn_s     <= btn_meta;
            btn_deb_d <= btn_deb;
            if (btn_s == btn_deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                // DEB_CYC consecutive cycles of disagreement: accept.
                deb_cnt <= '0;
                btn_deb <= btn_s;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // Edges seen while free-running are dropped, not remembered.
    assign step_hit = btn_deb & ~btn_deb_d & ~run_s;
`else
    logic unused_step_btn;
    assign unused_step_btn = step_btn;
    assign step_hit = 1'b0;
`endif

    // Registered so the FSM's clock is glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_tick <= 1'b0;
        end else begin
            fsm_tick <= div_hit | step_hit;
        end
    end

    // ---------------- digit values ----------------
    logic [3:0] digit_val [NUM_DIG];

    assign digit_val[0] = 4'(dut_out);
    assign digit_val[1] = 4'h0;
    assign digit_val[2] = 4'(dut_state);
    assign digit_val[3] = 4'h0;

    generate
        if (NUM_DIG > 4) begin : g_cnt
            logic [CNT_W-1:0] trans_cnt;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    trans_cnt <= '0;
                end else if (fsm_tick) begin
                    trans_cnt <= trans_cnt + CNT_W'(1);
                end
            end

            for (genvar gi = 0; gi < NUM_DIG - 4; gi++) begin : g_nib
                assign digit_val[4 + gi] = trans_cnt[4*gi +: 4];
            end
        end
    endgenerate

    // ---------------- display scan ----------------
    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  dig_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt <= '0;
            dig_idx  <= '0;
            AN       <= '1;
            CA       <= 7'h7F;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                dig_idx  <= (dig_idx == IDX_LAST) ? '0 : dig_idx + IDX_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            AN <= ~(NUM_DIG'(1) << dig_idx);
            CA <= seg_font(digit_val[dig_idx]);
        end
    end

endmodule

// File: tb/tb_fsm_monitor.sv
// Self-checking bench for fsm_monitor with small clock-rate parameters
// (DIV=10, SCAN_DIV=4, DEB_CYC=5, six digits). Expectations are worked out
// by hand from the clock-edge timing; a two-digit transition-count model
// tracks ticks observed on fsm_tick.

module tb_fsm_monitor;

    logic       clk;
    logic       reset;
    logic       run;
    logic       step_btn;
    logic [2:0] dut_state;
    logic [0:0] dut_out;
    logic       fsm_tick;
    logic [5:0] AN;
    logic [6:0] CA;

    fsm_monitor #(
        .CLK_HZ (1000),
        .TICK_HZ(100),
        .SCAN_HZ(250),
        .DEB_CYC(5),
        .STATE_W(3),
        .OUT_W  (1),
        .NUM_DIG(6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .step_btn (step_btn),
        .dut_state(dut_state),
        .dut_out  (dut_out),
        .fsm_tick (fsm_tick),
        .AN       (AN),
        .CA       (CA)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         total = 0;
    int         bad   = 0;
    int         ticks = 0;
    int         cyc_n = 0;
    logic [7:0] model_count = 8'h00;
    bit         btn_wiggle = 1'b0;

    typedef struct {
        logic [2:0] st;
        logic       o;
        logic [6:0] ca0;
        logic [6:0] ca2;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // One clock cycle, ending on the falling edge where outputs are sampled.
    task automatic step_cyc();
        @(negedge clk);
        cyc_n++;
        if (btn_wiggle) step_btn = ((cyc_n / 7) % 2) != 0;
        if (fsm_tick === 1'b1) begin
            ticks++;
            model_count = model_count + 8'h01;
        end
    endtask

    // Cycles until the next tick; -1 when none appears within the budget.
    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            step_cyc();
            n++;
        end while (fsm_tick !== 1'b1 && n < budget);
        if (fsm_tick !== 1'b1) n = -1;
    endtask

    // Waits for the given digit to be driven and returns its segments.
    task automatic read_digit(input int idx, output logic [6:0] ca);
        logic [5:0] want;
        bit         found;
        want  = ~(6'b000001 << idx);
        found = 1'b0;
        ca    = 7'bx;
        for (int i = 0; i < 40 && !found; i++) begin
            step_cyc();
            if (AN === want) begin
                found = 1'b1;
                ca    = CA;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_count = 8'h00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ca;
        logic [5:0] an_exp;
        logic [6:0] scan_ca [6];
        int         n;
        int         t0;

        reset     = 1'b0;
        run       = 1'b0;
        step_btn  = 1'b0;
        dut_state = 3'd5;
        dut_out   = 1'b1;

        vecs[0] = '{st: 3'd5, o: 1'b1, ca0: 7'h79, ca2: 7'h12};
        vecs[1] = '{st: 3'd0, o: 1'b0, ca0: 7'h40, ca2: 7'h40};
        vecs[2] = '{st: 3'd7, o: 1'b0, ca0: 7'h40, ca2: 7'h78};
        vecs[3] = '{st: 3'd2, o: 1'b1, ca0: 7'h79, ca2: 7'h24};
        vecs[4] = '{st: 3'd3, o: 1'b0, ca0: 7'h40, ca2: 7'h30};
        vecs[5] = '{st: 3'd6, o: 1'b1, ca0: 7'h79, ca2: 7'h02};
        vecs[6] = '{st: 3'd4, o: 1'b0, ca0: 7'h40, ca2: 7'h19};
        vecs[7] = '{st: 3'd1, o: 1'b1, ca0: 7'h79, ca2: 7'h79};

        scan_ca[0] = 7'h79; scan_ca[1] = 7'h40; scan_ca[2] = 7'h12;
        scan_ca[3] = 7'h40; scan_ca[4] = 7'h40; scan_ca[5] = 7'h40;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tick", 32'(fsm_tick), 32'h0);
        chk("rst_an", 32'(AN), 32'h3F);
        chk("rst_ca", 32'(CA), 32'h7F);

        // Scan order and segment content, state=5 out=1, count=0
        reset = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step_cyc();
            an_exp = ~(6'b000001 << (((k - 1) / 4) % 6));
            chk($sformatf("scan_an_k%0d", k), 32'(AN), 32'(an_exp));
            chk($sformatf("scan_ca_k%0d", k), 32'(CA), 32'(scan_ca[((k - 1) / 4) % 6]));
        end

        // Table: state/output digits
        for (int i = 0; i < 8; i++) begin
            dut_state = vecs[i].st;
            dut_out   = vecs[i].o;
            read_digit(0, ca);
            chk($sformatf("vec%0d_d0", i), 32'(ca), 32'(vecs[i].ca0));
            read_digit(1, ca);
            chk($sformatf("vec%0d_d1", i), 32'(ca), 32'h40);
            read_digit(2, ca);
            chk($sformatf("vec%0d_d2", i), 32'(ca), 32'(vecs[i].ca2));
        end

        // Free-run from reset with run already high
        run = 1'b1;
        do_reset();
        wait_tick(30, n);
        chk("fr_first_lat", 32'(n), 32'd12);
        for (int i = 1; i < 16; i++) begin
            wait_tick(30, n);
            chk($sformatf("fr_interval%0d", i), 32'(n), 32'd10);
        end
        run = 1'b0;
        repeat (5) step_cyc();
        read_digit(4, ca);
        chk("cnt16_d4", 32'(ca), 32'h40);
        read_digit(5, ca);
        chk("cnt16_d5", 32'(ca), 32'h79);

        // Count to 0xFF, then one more tick wraps to 0x00
        run = 1'b1;
        n = 0;
        while (model_count != 8'hFF && n < 3000) begin
            step_cyc();
            n++;
        end
        run = 1'b0;
        repeat (5) step_cyc();
        read_digit(4, ca);
        chk("cntFF_d4", 32'(ca), 32'h0E);
        read_digit(5, ca);
        chk("cntFF_d5", 32'(ca), 32'h0E);
        run = 1'b1;
        wait_tick(30, n);
        chk("resume_lat", 32'(n), 32'd12);
        run = 1'b0;
        repeat (5) step_cyc();
        read_digit(4, ca);
        chk("wrap_d4", 32'(ca), 32'h40);
        read_digit(5, ca);
        chk("wrap_d5", 32'(ca), 32'h40);

        // Halt landing on divider=9 keeps that tick, then nothing
        run = 1'b1;
        wait_tick(30, n);
        chk("ms_start_lat", 32'(n), 32'd12);
        repeat (7) step_cyc();
        run = 1'b0;
        repeat (3) step_cyc();
        chk("ms_kept_tick", 32'(fsm_tick), 32'h1);
        t0 = ticks;
        repeat (30) step_cyc();
        chk("ms_halted", 32'(ticks - t0), 32'd0);

        // Single-step path
`ifdef FSM_MONITOR_STEP_EN
        t0 = ticks;
        step_btn = 1'b1;
        wait_tick(20, n);
        chk("step_lat", 32'(n), 32'd8);
        repeat (2) step_cyc();
        step_btn = 1'b0;
        repeat (20) step_cyc();
        chk("step_one_tick", 32'(ticks - t0), 32'd1);
        t0 = ticks;
        step_btn = 1'b1;
        repeat (3) step_cyc();
        step_btn = 1'b0;
        repeat (20) step_cyc();
        chk("step_glitch", 32'(ticks - t0), 32'd0);
`else
        t0 = ticks;
        for (int p = 0; p < 5; p++) begin
            step_btn = 1'b1;
            repeat (10) step_cyc();
            step_btn = 1'b0;
            repeat (30) step_cyc();
        end
        chk("halt_no_ticks", 32'(ticks - t0), 32'd0);
`endif

        // Button activity during free-run does not disturb the spacing
        run = 1'b1;
        wait_tick(30, n);
        chk("ign_first_lat", 32'(n), 32'd12);
        btn_wiggle = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_tick(30, n);
            chk($sformatf("ign_interval%0d", i), 32'(n), 32'd10);
        end
        btn_wiggle = 1'b0;
        step_btn   = 1'b0;
        wait_tick(30, n);
        chk("ign_last", 32'(n), 32'd10);
        run = 1'b0;
        t0 = ticks;
        repeat (20) step_cyc();
        chk("ign_no_queue", 32'(ticks - t0), 32'd0);

        // Asynchronous reset during a tick
        run = 1'b1;
        wait_tick(30, n);
        chk("pre_rst_lat", 32'(n), 32'd12);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_tick", 32'(fsm_tick), 32'h0);
        chk("mid_rst_an", 32'(AN), 32'h3F);
        chk("mid_rst_ca", 32'(CA), 32'h7F);
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("held_rst_an", 32'(AN), 32'h3F);
        reset = 1'b1;
        model_count = 8'h00;
        repeat (3) step_cyc();
        read_digit(4, ca);
        chk("post_rst_d4", 32'(ca), 32'h40);
        read_digit(5, ca);
        chk("post_rst_d5", 32'(ca), 32'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
